// File: rtl/cpu_pio_edge_in.sv
// Avalon-MM input PIO: synchronizes an external bus, captures per-bit edges into a
// sticky W1C register and raises a maskable level interrupt.
`timescale 1ns/1ps

module cpu_pio_edge_in_lane #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    input  logic arm_i,
    input  logic clr_i,
    output logic sync_o,
    output logic cap_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_q;
    logic                   cap_q, cap_d;
    logic                   edge_w;

    always_comb begin
        edge_w = 1'b0;
        case (EDGE_TYPE)
            0:       edge_w =  sync_q[SYNC_STAGES-1] & ~sync_d_q;
            1:       edge_w = ~sync_q[SYNC_STAGES-1] &  sync_d_q;
            default: edge_w =  sync_q[SYNC_STAGES-1] ^  sync_d_q;
        endcase
    end

    // Set has priority over a same-cycle W1C clear.
    assign cap_d = (edge_w & arm_i) | (cap_q & ~clr_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            sync_d_q <= 1'b0;
            cap_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], in_i};
            sync_d_q <= sync_q[SYNC_STAGES-1];
            cap_q    <= cap_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign cap_o  = cap_q;
endmodule

module cpu_pio_edge_in #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

    logic [2:0]       warm_q, warm_d;
    logic             warm_done;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] sync_w, cap_w, clr_w;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign warm_done    = (warm_q == WARM_MAX);
    assign clr_w        = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // Captures stay disarmed until the synchronizer and sync_d hold post-reset input.
    assign warm_d = warm_done ? warm_q : warm_q + 3'd1;
    assign mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_q <= '0;
            mask_q <= '0;
        end else begin
            warm_q <= warm_d;
            mask_q <= mask_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        cpu_pio_edge_in_lane #(
            .SYNC_STAGES(SYNC_STAGES),
            .EDGE_TYPE  (EDGE_TYPE)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[i]),
            .arm_i  (warm_done),
            .clr_i  (clr_w[i]),
            .sync_o (sync_w[i]),
            .cap_o  (cap_w[i])
        );
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = sync_w;
            2'd2:    readdata[WIDTH-1:0] = mask_q;
            2'd3:    readdata[WIDTH-1:0] = cap_w;
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap_w & mask_q);
endmodule

// File: tb/tb_cpu_pio_edge_in.sv
// Directed bench: rising-edge instance driven from a vector table, any-edge instance
// exercised by hand sequences including an asynchronous mid-run reset.
`timescale 1ns/1ps

module tb_cpu_pio_edge_in;
    logic        clk, reset_n;
    logic [1:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata;
    logic [7:0]  in0, in2;
    logic [31:0] rd0, rd2;
    logic        irq0, irq2;

    int checks = 0;
    int errors = 0;

    cpu_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irq0)
    );

    cpu_pio_edge_in #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irq2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wr;
        logic [31:0] wdata;
        logic [7:0]  inp;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [1:0] a, input logic cs, input logic wr,
                       input logic [31:0] wd, input logic [7:0] inp,
                       input logic [31:0] erd, input logic eirq);
        vec_t v;
        v.addr = a; v.cs = cs; v.wr = wr; v.wdata = wd; v.inp = inp;
        v.exp_rd = erd; v.exp_irq = eirq;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [1:0] a, input logic wr, input logic [31:0] wd);
        address    = a;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wd;
    endtask

    initial begin
        reset_n = 1'b0;
        bus(2'd0, 1'b0, 32'h0);
        in0 = 8'hFF;
        in2 = 8'h00;

        // Each row: inputs applied at negedge, outputs checked 1 ns later (pre-edge state).
        add(0,1,0,32'h0,8'h00,32'hFF,0);
        add(0,1,0,32'h0,8'h00,32'hFF,0);
        add(0,1,0,32'h0,8'h00,32'h00,0);
        add(2,1,1,32'h1,8'h00,32'h00,0);
        add(2,1,0,32'h0,8'h01,32'h01,0);   // bit 0 rises before edge k
        add(0,1,0,32'h0,8'h01,32'h00,0);
        add(0,1,0,32'h0,8'h01,32'h01,0);   // data visible after k+1
        add(3,1,0,32'h0,8'h00,32'h01,1);   // captured after k+2, bit falls
        add(3,1,0,32'h0,8'h00,32'h01,1);
        add(3,1,0,32'h0,8'h00,32'h01,1);
        add(0,1,0,32'h0,8'h04,32'h00,1);   // falling edge did not clear
        add(3,1,0,32'h0,8'h04,32'h01,1);
        add(3,1,0,32'h0,8'h04,32'h01,1);
        add(3,1,1,32'h4,8'h04,32'h05,1);   // W1C bit 2
        add(3,1,1,32'h1,8'h04,32'h01,1);   // W1C bit 0
        add(3,1,0,32'h0,8'h0C,32'h00,0);
        add(3,1,0,32'h0,8'h0C,32'h00,0);
        add(3,1,1,32'h8,8'h0C,32'h00,0);   // clear lands on bit 3 set edge
        add(3,1,0,32'h0,8'h0C,32'h08,0);
        add(2,1,1,32'h0,8'h0C,32'h01,0);
        add(3,1,1,32'h8,8'h00,32'h08,0);
        add(3,1,0,32'h0,8'h00,32'h00,0);
        add(3,1,0,32'h0,8'h00,32'h00,0);
        add(3,1,0,32'h0,8'h06,32'h00,0);
        add(3,1,0,32'h0,8'h06,32'h00,0);
        add(3,1,0,32'h0,8'h06,32'h00,0);
        add(3,1,0,32'h0,8'h06,32'h06,0);   // pending, fully masked
        add(2,1,1,32'h4,8'h06,32'h00,0);
        add(3,1,0,32'h0,8'h06,32'h06,1);   // unmask raises irq
        add(3,1,1,32'h4,8'h06,32'h06,1);
        add(3,1,0,32'h0,8'h06,32'h02,0);   // bit 1 still pending, irq low
        add(1,1,1,32'hFFFFFFFF,8'h06,32'h00,0);
        add(0,1,1,32'hFFFFFFFF,8'h06,32'h06,0);
        add(2,1,0,32'h0,8'h06,32'h04,0);
        add(3,0,1,32'h2,8'h06,32'h02,0);   // no chipselect, write ignored
        add(3,1,0,32'h0,8'h06,32'h02,0);
        add(3,1,1,32'h2,8'h06,32'h02,0);
        add(3,1,0,32'h0,8'h06,32'h00,0);

        #23 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus(2'd0, 1'b0, 32'h0); #1 chk("reset_data", rd0, 32'hFF);
        chk("reset_irq", {31'h0, irq0}, 32'h0);
        bus(2'd3, 1'b0, 32'h0); #1 chk("reset_ecap", rd0, 32'h0);
        bus(2'd2, 1'b0, 32'h0); #1 chk("reset_mask", rd0, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            address    = tbl[i].addr;
            chipselect = tbl[i].cs;
            write_n    = ~tbl[i].wr;
            writedata  = tbl[i].wdata;
            in0        = tbl[i].inp;
            #1;
            chk($sformatf("vec%0d_rd", i), rd0, tbl[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'h0, irq0}, {31'h0, tbl[i].exp_irq});
        end

        // Any-edge instance: rise captures, clear, fall re-captures.
        @(negedge clk); bus(2'd2, 1'b1, 32'h80);
        @(negedge clk); bus(2'd3, 1'b0, 32'h0); in2 = 8'h80;
        repeat (3) @(negedge clk);
        #1 chk("any_rise_ecap", rd2, 32'h80);
        chk("any_rise_irq", {31'h0, irq2}, 32'h1);
        chk("rise_inst_irq", {31'h0, irq0}, 32'h0);
        bus(2'd3, 1'b1, 32'h80); in2 = 8'h00;
        @(negedge clk); bus(2'd3, 1'b0, 32'h0);
        #1 chk("any_cleared", rd2, 32'h0);
        chk("any_cleared_irq", {31'h0, irq2}, 32'h0);
        @(negedge clk);
        #1 chk("any_wait", rd2, 32'h0);
        @(negedge clk);
        #1 chk("any_fall_ecap", rd2, 32'h80);
        chk("any_fall_irq", {31'h0, irq2}, 32'h1);

        // Short asynchronous reset between clock edges.
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        chk("mid_irq2", {31'h0, irq2}, 32'h0);
        chk("mid_irq0", {31'h0, irq0}, 32'h0);
        bus(2'd0, 1'b0, 32'h0); #1 chk("mid_data2", rd2, 32'h0);
        chk("mid_data0", rd0, 32'h0);
        bus(2'd1, 1'b0, 32'h0); #1 chk("mid_rsvd2", rd2, 32'h0);
        bus(2'd2, 1'b0, 32'h0); #1 chk("mid_mask2", rd2, 32'h0);
        chk("mid_mask0", rd0, 32'h0);
        bus(2'd3, 1'b0, 32'h0); #1 chk("mid_ecap2", rd2, 32'h0);

        // Held-high inputs across reset release must not capture.
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus(2'd3, 1'b0, 32'h0); #1 chk("warm_ecap0", rd0, 32'h0);
        bus(2'd0, 1'b0, 32'h0); #1 chk("warm_data0", rd0, 32'h06);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
